// File: rtl/warp_scoreboard_pkg.sv
// Shared sizes, packet field layout and register-field types for the warp scoreboard.
package warp_scoreboard_pkg;

    localparam int NUM_WARP     = 4;
    localparam int NUM_WARP_LOG = 2;
    localparam int SIZE_REGFILE = 5;
    localparam int NUM_SLOT     = 4;
    localparam int NUM_SLOT_LOG = 2;
    localparam int NUM_SRC      = 3;

    // One register field is {valid, index}; sources are packed low-to-high in the decoded bus.
    localparam int REG_FIELD_W  = SIZE_REGFILE + 1;
    localparam int SRC_BUS_W    = NUM_SRC * REG_FIELD_W;
    localparam int PCOUNT_W     = NUM_SLOT_LOG + 1;

    typedef struct packed {
        logic                    valid;
        logic [SIZE_REGFILE-1:0] idx;
    } reg_field_t;

    typedef struct packed {
        logic                     valid;
        reg_field_t               dst;
        reg_field_t [NUM_SRC-1:0] src;
    } operand_entry_t;

    // Bit offset of source operand k within a decodedSrc bus.
    function automatic int src_offset(input int k);
        return k * REG_FIELD_W;
    endfunction

    // A register field collides with a pending slot only when both are valid.
    function automatic logic reg_match(input reg_field_t f, input logic slot_valid,
                                       input logic [SIZE_REGFILE-1:0] slot_reg);
        return f.valid && slot_valid && (f.idx == slot_reg);
    endfunction

endpackage

// File: rtl/scoreboard_warp_table.sv
// Pending-destination slots of one warp: allocation, writeback clear, occupancy and hazard compare.
module scoreboard_warp_table
    import warp_scoreboard_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alloc_valid,
    input  logic [SIZE_REGFILE-1:0] alloc_reg,
    input  logic                    wb_valid,
    input  logic [SIZE_REGFILE-1:0] wb_reg,
    input  operand_entry_t          entry0,
    input  operand_entry_t          entry1,
    output logic                    hazard0,
    output logic                    hazard1,
    output logic [PCOUNT_W-1:0]     pending_count
);

    logic [NUM_SLOT-1:0]     slot_valid;
    logic [SIZE_REGFILE-1:0] slot_reg [NUM_SLOT];
    logic [NUM_SLOT-1:0]     alloc_sel;
    logic [NUM_SLOT-1:0]     wb_clear;
    logic                    slots_full;
    logic                    slot_hit0;
    logic                    slot_hit1;
    logic                    intra_dep;

    // Lowest-index free slot, chosen from the occupancy at the start of the cycle.
    always_comb begin
        logic found;
        alloc_sel = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_SLOT; i++) begin
            if (!slot_valid[i] && !found) begin
                alloc_sel[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    // Every valid slot holding the written-back register is released.
    always_comb begin
        wb_clear = '0;
        for (int i = 0; i < NUM_SLOT; i++) begin
            wb_clear[i] = wb_valid && slot_valid[i] && (slot_reg[i] == wb_reg);
        end
    end

    // Slot state; an allocated slot was free, so it can never also be a writeback target.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid <= '0;
            for (int i = 0; i < NUM_SLOT; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOT; i++) begin
                if (alloc_valid && alloc_sel[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_reg[i]   <= alloc_reg;
                end else if (wb_clear[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Occupancy count of this warp.
    always_comb begin
        pending_count = '0;
        for (int i = 0; i < NUM_SLOT; i++) begin
            pending_count = pending_count + PCOUNT_W'(slot_valid[i]);
        end
    end

    // RAW/WAW compare of both buffer entries against the pending slots.
    always_comb begin
        slot_hit0 = 1'b0;
        slot_hit1 = 1'b0;
        for (int s = 0; s < NUM_SLOT; s++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                slot_hit0 = slot_hit0 | reg_match(entry0.src[k], slot_valid[s], slot_reg[s]);
                slot_hit1 = slot_hit1 | reg_match(entry1.src[k], slot_valid[s], slot_reg[s]);
            end
            slot_hit0 = slot_hit0 | reg_match(entry0.dst, slot_valid[s], slot_reg[s]);
            slot_hit1 = slot_hit1 | reg_match(entry1.dst, slot_valid[s], slot_reg[s]);
        end
    end

    // Entry 1 must wait behind entry 0 when it reads or rewrites entry 0's destination.
    always_comb begin
        intra_dep = 1'b0;
        if (entry0.valid && entry0.dst.valid && entry1.valid) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                intra_dep = intra_dep | reg_match(entry1.src[k], 1'b1, entry0.dst.idx);
            end
            intra_dep = intra_dep | reg_match(entry1.dst, 1'b1, entry0.dst.idx);
        end
    end

    // Final hazard bits; a full table blocks anything that would need a new slot.
    always_comb begin
        slots_full = &slot_valid;
        hazard0    = entry0.valid && (slot_hit0 || (entry0.dst.valid && slots_full));
        hazard1    = (entry1.valid && (slot_hit1 || (entry1.dst.valid && slots_full))) || intra_dep;
    end

endmodule

// File: rtl/warp_scoreboard.sv
// Per-warp register scoreboard: captures decoded operand fields, tracks issued destinations, flags hazards.
module warp_scoreboard
    import warp_scoreboard_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_WARP_LOG-1:0]        decodedWarp_i,
    input  logic [1:0]                     decodedValid_i,
    input  logic [SRC_BUS_W-1:0]           decodedSrc0_i,
    input  logic [SRC_BUS_W-1:0]           decodedSrc1_i,
    input  logic [REG_FIELD_W-1:0]         decodedDst0_i,
    input  logic [REG_FIELD_W-1:0]         decodedDst1_i,
    input  logic                           issueValid_i,
    input  logic [NUM_WARP_LOG-1:0]        issueWarp_i,
    input  logic                           issueEntry_i,
    input  logic                           wbValid_i,
    input  logic [NUM_WARP_LOG-1:0]        wbWarp_i,
    input  logic [SIZE_REGFILE-1:0]        wbReg_i,
    input  logic                           flush_i,
    input  logic [NUM_WARP_LOG-1:0]        flushWarp_i,
    input  logic                           stall_i,
    output logic [NUM_WARP-1:0]            hazardVector0_o,
    output logic [NUM_WARP-1:0]            hazardVector1_o,
    output logic [NUM_WARP*PCOUNT_W-1:0]   pendingCount_o,
    output logic                           sbIdle_o
);

    operand_entry_t                 entry_q [NUM_WARP][2];
    operand_entry_t                 dec_entry [2];
    logic                           flush_dec;
    logic                           flush_iss;
    logic                           issue_fire;
    logic                           issued_valid;
    reg_field_t                     issued_dst;
    logic [NUM_WARP-1:0]            alloc_valid;
    logic [NUM_WARP-1:0]            wb_hit;

    // Unpack the decoded buses into operand entries.
    always_comb begin
        dec_entry[0]       = '0;
        dec_entry[1]       = '0;
        dec_entry[0].valid = 1'b1;
        dec_entry[1].valid = 1'b1;
        dec_entry[0].dst   = reg_field_t'(decodedDst0_i);
        dec_entry[1].dst   = reg_field_t'(decodedDst1_i);
        for (int k = 0; k < NUM_SRC; k++) begin
            dec_entry[0].src[k] = reg_field_t'(decodedSrc0_i[src_offset(k) +: REG_FIELD_W]);
            dec_entry[1].src[k] = reg_field_t'(decodedSrc1_i[src_offset(k) +: REG_FIELD_W]);
        end
    end

    // A flush of a warp overrides decode and issue aimed at that same warp.
    always_comb begin
        flush_dec    = flush_i && (flushWarp_i == decodedWarp_i);
        flush_iss    = flush_i && (flushWarp_i == issueWarp_i);
        issue_fire   = !stall_i && issueValid_i && !flush_iss;
        issued_valid = entry_q[issueWarp_i][issueEntry_i].valid;
        issued_dst   = entry_q[issueWarp_i][issueEntry_i].dst;
    end

    // Operand entries: issue and flush invalidate, a new packet overwrites; all frozen while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARP; w++) begin
                entry_q[w][0] <= '0;
                entry_q[w][1] <= '0;
            end
        end else if (!stall_i) begin
            for (int w = 0; w < NUM_WARP; w++) begin
                for (int e = 0; e < 2; e++) begin
                    if (issue_fire && (issueWarp_i == NUM_WARP_LOG'(w)) && (issueEntry_i == 1'(e))) begin
                        entry_q[w][e].valid <= 1'b0;
                    end
                    if (flush_i && (flushWarp_i == NUM_WARP_LOG'(w))) begin
                        entry_q[w][e].valid <= 1'b0;
                    end
                    if (decodedValid_i[e] && !flush_dec && (decodedWarp_i == NUM_WARP_LOG'(w))) begin
                        entry_q[w][e] <= dec_entry[e];
                    end
                end
            end
        end
    end

    // Per-warp slot requests: allocate on issue of a valid entry with a destination; writeback is never stalled.
    always_comb begin
        alloc_valid = '0;
        wb_hit      = '0;
        for (int w = 0; w < NUM_WARP; w++) begin
            alloc_valid[w] = issue_fire && (issueWarp_i == NUM_WARP_LOG'(w)) && issued_valid && issued_dst.valid;
            wb_hit[w]      = wbValid_i && (wbWarp_i == NUM_WARP_LOG'(w));
        end
    end

    genvar gw;
    generate
        for (gw = 0; gw < NUM_WARP; gw++) begin : g_warp
            scoreboard_warp_table u_table (
                .clk           (clk),
                .reset         (reset),
                .alloc_valid   (alloc_valid[gw]),
                .alloc_reg     (issued_dst.idx),
                .wb_valid      (wb_hit[gw]),
                .wb_reg        (wbReg_i),
                .entry0        (entry_q[gw][0]),
                .entry1        (entry_q[gw][1]),
                .hazard0       (hazardVector0_o[gw]),
                .hazard1       (hazardVector1_o[gw]),
                .pending_count (pendingCount_o[gw*PCOUNT_W +: PCOUNT_W])
            );
        end
    endgenerate

    // Idle when no warp has anything in flight.
    always_comb begin
        sbIdle_o = (pendingCount_o == '0);
    end

endmodule

// File: tb/tb_warp_scoreboard.sv
// Self-checking bench for warp_scoreboard: a table of per-cycle vectors plus hand-written corner sequences.
module tb_warp_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  decodedWarp_i;
    logic [1:0]  decodedValid_i;
    logic [17:0] decodedSrc0_i, decodedSrc1_i;
    logic [5:0]  decodedDst0_i, decodedDst1_i;
    logic        issueValid_i;
    logic [1:0]  issueWarp_i;
    logic        issueEntry_i;
    logic        wbValid_i;
    logic [1:0]  wbWarp_i;
    logic [4:0]  wbReg_i;
    logic        flush_i;
    logic [1:0]  flushWarp_i;
    logic        stall_i;
    logic [3:0]  hazardVector0_o, hazardVector1_o;
    logic [11:0] pendingCount_o;
    logic        sbIdle_o;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    warp_scoreboard dut (
        .clk             (clk),
        .reset           (reset),
        .decodedWarp_i   (decodedWarp_i),
        .decodedValid_i  (decodedValid_i),
        .decodedSrc0_i   (decodedSrc0_i),
        .decodedSrc1_i   (decodedSrc1_i),
        .decodedDst0_i   (decodedDst0_i),
        .decodedDst1_i   (decodedDst1_i),
        .issueValid_i    (issueValid_i),
        .issueWarp_i     (issueWarp_i),
        .issueEntry_i    (issueEntry_i),
        .wbValid_i       (wbValid_i),
        .wbWarp_i        (wbWarp_i),
        .wbReg_i         (wbReg_i),
        .flush_i         (flush_i),
        .flushWarp_i     (flushWarp_i),
        .stall_i         (stall_i),
        .hazardVector0_o (hazardVector0_o),
        .hazardVector1_o (hazardVector1_o),
        .pendingCount_o  (pendingCount_o),
        .sbIdle_o        (sbIdle_o)
    );

    typedef struct {
        logic        st;
        logic        fl;
        logic [1:0]  fw;
        logic [1:0]  dv;
        logic [1:0]  dw;
        logic [17:0] s0, s1;
        logic [5:0]  d0, d1;
        logic        iv;
        logic [1:0]  iw;
        logic        ie;
        logic        wv;
        logic [1:0]  ww;
        logic [4:0]  wr;
        logic [3:0]  h0, h1;
        logic [11:0] pc;
    } vec_t;

    typedef struct {
        string       name;
        logic [3:0]  h0, h1;
        logic [11:0] pc;
        logic        idle;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    function automatic logic [5:0] r(input int i);
        return {1'b1, 5'(i)};
    endfunction

    function automatic logic [17:0] sx(input logic [5:0] f);
        return {12'd0, f};
    endfunction

    function automatic vec_t nop();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        stall_i        = v.st;
        flush_i        = v.fl;
        flushWarp_i    = v.fw;
        decodedValid_i = v.dv;
        decodedWarp_i  = v.dw;
        decodedSrc0_i  = v.s0;
        decodedSrc1_i  = v.s1;
        decodedDst0_i  = v.d0;
        decodedDst1_i  = v.d1;
        issueValid_i   = v.iv;
        issueWarp_i    = v.iw;
        issueEntry_i   = v.ie;
        wbValid_i      = v.wv;
        wbWarp_i       = v.ww;
        wbReg_i        = v.wr;
    endtask

    task automatic compare_pop();
        exp_t e;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL scoreboard_empty: output observed with no expectation queued");
            return;
        end
        e = exp_q.pop_front();
        if (hazardVector0_o !== e.h0 || hazardVector1_o !== e.h1 ||
            pendingCount_o !== e.pc || sbIdle_o !== e.idle) begin
            tests_failed++;
            $display("FAIL %s: got h0=%b h1=%b pc=%h idle=%b, want h0=%b h1=%b pc=%h idle=%b",
                     e.name, hazardVector0_o, hazardVector1_o, pendingCount_o, sbIdle_o,
                     e.h0, e.h1, e.pc, e.idle);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare just after the edge.
    task automatic apply(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        drive(v);
        e.name = name;
        e.h0   = v.h0;
        e.h1   = v.h1;
        e.pc   = v.pc;
        e.idle = (v.pc == 12'h000);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    initial begin
        vec_t v;

        // warp1 basic RAW
        v = nop(); v.dv = 2'b01; v.dw = 1; v.s0 = sx(r(3)); v.d0 = r(4);         tbl.push_back(v);
        v = nop(); v.iv = 1; v.iw = 1; v.pc = 12'h008;                           tbl.push_back(v);
        v = nop(); v.dv = 2'b01; v.dw = 1; v.s0 = sx(r(4)); v.d0 = r(5);
                   v.h0 = 4'b0010; v.pc = 12'h008;                               tbl.push_back(v);
        v = nop(); v.wv = 1; v.ww = 1; v.wr = 4;                                 tbl.push_back(v);
        // warp2 intra-pair then slot hazard
        v = nop(); v.dv = 2'b11; v.dw = 2; v.d0 = r(7); v.s1 = sx(r(7)); v.d1 = r(8);
                   v.h1 = 4'b0100;                                               tbl.push_back(v);
        v = nop(); v.iv = 1; v.iw = 2; v.h1 = 4'b0100; v.pc = 12'h040;           tbl.push_back(v);
        v = nop(); v.wv = 1; v.ww = 2; v.wr = 7;                                 tbl.push_back(v);
        v = nop(); v.iv = 1; v.iw = 2; v.ie = 1; v.pc = 12'h040;                 tbl.push_back(v);
        v = nop(); v.wv = 1; v.ww = 2; v.wr = 8;                                 tbl.push_back(v);
        // warp0 fill all slots
        v = nop(); v.dv = 2'b11; v.dw = 0; v.d0 = r(1); v.d1 = r(2);             tbl.push_back(v);
        v = nop(); v.iv = 1; v.iw = 0; v.pc = 12'h001;                           tbl.push_back(v);
        v = nop(); v.iv = 1; v.iw = 0; v.ie = 1; v.pc = 12'h002;                 tbl.push_back(v);
        v = nop(); v.dv = 2'b11; v.dw = 0; v.d0 = r(3); v.d1 = r(4); v.pc = 12'h002; tbl.push_back(v);
        v = nop(); v.iv = 1; v.iw = 0; v.pc = 12'h003;                           tbl.push_back(v);
        v = nop(); v.iv = 1; v.iw = 0; v.ie = 1; v.pc = 12'h004;                 tbl.push_back(v);
        v = nop(); v.dv = 2'b01; v.dw = 0; v.d0 = r(9); v.h0 = 4'b0001; v.pc = 12'h004; tbl.push_back(v);
        v = nop(); v.wv = 1; v.ww = 0; v.wr = 2; v.pc = 12'h003;                 tbl.push_back(v);
        v = nop(); v.iv = 1; v.iw = 0; v.pc = 12'h004;                           tbl.push_back(v);
        v = nop(); v.dv = 2'b10; v.dw = 0; v.s1 = sx(r(9)); v.h1 = 4'b0001; v.pc = 12'h004; tbl.push_back(v);
        v = nop(); v.wv = 1; v.ww = 0; v.wr = 1; v.h1 = 4'b0001; v.pc = 12'h003; tbl.push_back(v);
        v = nop(); v.wv = 1; v.ww = 0; v.wr = 9; v.pc = 12'h002;                 tbl.push_back(v);
        v = nop(); v.wv = 1; v.ww = 0; v.wr = 3; v.pc = 12'h001;                 tbl.push_back(v);
        v = nop(); v.wv = 1; v.ww = 0; v.wr = 4;                                 tbl.push_back(v);
        // warp3 flush with same-cycle decode and issue
        v = nop(); v.dv = 2'b11; v.dw = 3; v.d0 = r(10); v.d1 = r(11);           tbl.push_back(v);
        v = nop(); v.iv = 1; v.iw = 3; v.pc = 12'h200;                           tbl.push_back(v);
        v = nop(); v.fl = 1; v.fw = 3; v.dv = 2'b01; v.dw = 3; v.s0 = sx(r(10)); v.d0 = r(12);
                   v.iv = 1; v.iw = 3; v.ie = 1; v.pc = 12'h200;                 tbl.push_back(v);
        v = nop(); v.fl = 1; v.fw = 2; v.dv = 2'b01; v.dw = 3; v.s0 = sx(r(10));
                   v.h0 = 4'b1000; v.pc = 12'h200;                               tbl.push_back(v);
        v = nop(); v.wv = 1; v.ww = 3; v.wr = 10;                                tbl.push_back(v);
        // stall, and same-cycle issue + writeback of one register
        v = nop(); v.dv = 2'b01; v.dw = 2; v.d0 = r(5);                          tbl.push_back(v);
        v = nop(); v.iv = 1; v.iw = 2; v.pc = 12'h040;                           tbl.push_back(v);
        v = nop(); v.dv = 2'b01; v.dw = 2; v.d0 = r(6); v.pc = 12'h040;          tbl.push_back(v);
        v = nop(); v.st = 1; v.dv = 2'b10; v.dw = 2; v.d1 = r(6); v.iv = 1; v.iw = 2;
                   v.wv = 1; v.ww = 2; v.wr = 5;                                 tbl.push_back(v);
        v = nop(); v.iv = 1; v.iw = 2; v.pc = 12'h040;                           tbl.push_back(v);
        v = nop(); v.dv = 2'b01; v.dw = 2; v.d0 = r(6); v.h0 = 4'b0100; v.pc = 12'h040; tbl.push_back(v);
        v = nop(); v.iv = 1; v.iw = 2; v.wv = 1; v.ww = 2; v.wr = 6; v.pc = 12'h040; tbl.push_back(v);
        v = nop(); v.wv = 1; v.ww = 2; v.wr = 6;                                 tbl.push_back(v);

        // Reset state
        reset = 1'b1;
        drive(nop());
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (hazardVector0_o !== 4'b0 || hazardVector1_o !== 4'b0 ||
            pendingCount_o !== 12'h000 || sbIdle_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state: got h0=%b h1=%b pc=%h idle=%b, want 0 0 000 1",
                     hazardVector0_o, hazardVector1_o, pendingCount_o, sbIdle_o);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Writeback is not bypassed: hazard holds until the edge after writeback.
        v = nop(); v.dv = 2'b10; v.dw = 1; v.d1 = r(20);
        apply(v, "wb_setup_decode");
        v = nop(); v.iv = 1; v.iw = 1; v.ie = 1; v.pc = 12'h008;
        apply(v, "wb_setup_issue");
        v = nop(); v.dv = 2'b10; v.dw = 1; v.s1 = sx(r(20)); v.h1 = 4'b0010; v.pc = 12'h008;
        apply(v, "wb_raw_hazard");
        @(negedge clk);
        v = nop(); v.wv = 1; v.ww = 1; v.wr = 20;
        drive(v);
        #1;
        tests_run++;
        if (hazardVector1_o !== 4'b0010) begin
            tests_failed++;
            $display("FAIL wb_no_bypass: got h1=%b, want h1=0010", hazardVector1_o);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (hazardVector1_o !== 4'b0000 || pendingCount_o !== 12'h000 || sbIdle_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL wb_clears_next: got h1=%b pc=%h idle=%b, want 0000 000 1",
                     hazardVector1_o, pendingCount_o, sbIdle_o);
        end

        // Reset mid-operation discards pending slots.
        v = nop(); v.iv = 1; v.iw = 1; v.ie = 0; v.pc = 12'h008;
        apply(v, "pre_reset_issue");
        @(negedge clk);
        drive(nop());
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tests_run++;
        if (hazardVector0_o !== 4'b0 || hazardVector1_o !== 4'b0 ||
            pendingCount_o !== 12'h000 || sbIdle_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL midop_reset: got h0=%b h1=%b pc=%h idle=%b, want 0 0 000 1",
                     hazardVector0_o, hazardVector1_o, pendingCount_o, sbIdle_o);
        end

        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d leftover, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
